// File: rtl/conv3x3_mc_engine.sv
// conv3x3_mc_engine: streaming 3x3 valid convolution with N_OC output channels in parallel.
// Pixels arrive in raster order over valid/ready. Two line buffers and a 3x3 window feed
// registered products and then a registered sum/output stage.
// Optional build macro: CONV_RELU_EN clamps each negative channel sum to zero before dout.
module conv3x3_mc_engine #(
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 482,
    parameter int unsigned IMG_H = 482,
    parameter int unsigned N_OC  = 2
) (
    input  logic                         clk,
    input  logic                         Rst_n,
    input  logic                         start,
    input  logic [DW-1:0]                din,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic                         w_we,
    input  logic [$clog2(9*N_OC)-1:0]    w_addr,
    input  logic [DW-1:0]                w_data,
    output logic [N_OC*(2*DW+4)-1:0]     dout,
    output logic                         dout_valid,
    output logic                         busy,
    output logic                         frame_done
);
    localparam int unsigned OW = 2*DW + 4;
    localparam int unsigned PW = 2*DW;
    localparam int unsigned NW = 9*N_OC;
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nx;
    logic [1:0]         r_drain_cnt;
    logic               r_din_ready;
    logic               r_busy;
    logic               r_frame_done;
    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic               w_accept;
    logic               w_last;

    logic [NW*DW-1:0]   r_w;
    logic [DW-1:0]      r_lb1 [IMG_W];
    logic [DW-1:0]      r_lb2 [IMG_W];
    logic [DW-1:0]      w_lb1;
    logic [DW-1:0]      w_lb2;
    logic [9*DW-1:0]    r_win;

    logic [NW*PW-1:0]   w_prod;
    logic [NW*PW-1:0]   r_prod;
    logic [N_OC*OW-1:0] w_res;
    logic [N_OC*OW-1:0] r_dout;
    logic               r_v0;
    logic               r_v1;
    logic               r_dout_valid;

    assign w_accept = din_valid && r_din_ready;
    assign w_last   = (r_row == RW'(IMG_H-1)) && (r_col == CW'(IMG_W-1));
    assign w_lb1    = r_lb1[r_col];
    assign w_lb2    = r_lb2[r_col];

    // Next-state logic for IDLE -> RUN -> DRAIN -> IDLE.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nx = S_RUN;
            S_RUN:   if (w_accept && w_last) w_state_nx = S_DRAIN;
            S_DRAIN: if (r_drain_cnt == 2'd2) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register, registered control outputs and raster position counters.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= S_IDLE;
            r_drain_cnt  <= 2'd0;
            r_din_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_drain_cnt  <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
            r_din_ready  <= (w_state_nx == S_RUN);
            r_busy       <= (w_state_nx != S_IDLE);
            r_frame_done <= (r_state == S_DRAIN) && (w_state_nx == S_IDLE);
            if ((r_state == S_IDLE) && start) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                if (r_col == CW'(IMG_W-1)) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // Weight store: writable only while idle, out-of-range indices dropped.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_w <= '0;
        end else if ((r_state == S_IDLE) && w_we && (32'(w_addr) < NW)) begin
            r_w[w_addr*DW +: DW] <= w_data;
        end
    end

    // Line buffers hold rows r-1 and r-2; reads at r_col see pre-write data.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= din;
            r_lb2[r_col] <= r_lb1[r_col];
        end
    end

    // 3x3 window shifts left on each accept; slot ky*3+kx = pixel (r-2+ky, c-2+kx).
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_win <= '0;
        end else if (w_accept) begin
            for (int ky = 0; ky < 3; ky++) begin
                r_win[(ky*3)*DW +: DW]   <= r_win[(ky*3+1)*DW +: DW];
                r_win[(ky*3+1)*DW +: DW] <= r_win[(ky*3+2)*DW +: DW];
            end
            r_win[2*DW +: DW] <= w_lb2;
            r_win[5*DW +: DW] <= w_lb1;
            r_win[8*DW +: DW] <= din;
        end
    end

    for (genvar g = 0; g < NW; g++) begin : g_prod
        assign w_prod[g*PW +: PW] = PW'($signed(r_w[g*DW +: DW])) * PW'($signed(r_win[(g%9)*DW +: DW]));
    end

    for (genvar oc = 0; oc < N_OC; oc++) begin : g_sum
        logic signed [OW-1:0] w_acc;
        // Sign-extended nine-term sum for this channel.
        always_comb begin
            w_acc = '0;
            for (int k = 0; k < 9; k++) begin
                w_acc = w_acc + OW'($signed(r_prod[(oc*9+k)*PW +: PW]));
            end
        end
`ifdef CONV_RELU_EN
        assign w_res[oc*OW +: OW] = w_acc[OW-1] ? '0 : w_acc;
`else
        assign w_res[oc*OW +: OW] = w_acc;
`endif
    end

    // Result pipeline: valid tag at accept, products next edge, sum into dout after that.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_v0         <= 1'b0;
            r_v1         <= 1'b0;
            r_prod       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_v0         <= w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
            r_v1         <= r_v0;
            r_prod       <= w_prod;
            r_dout_valid <= r_v1;
            if (r_v1) begin
                r_dout <= w_res;
            end
        end
    end

    assign din_ready  = r_din_ready;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_conv3x3_mc_engine.sv
// tb_conv3x3_mc_engine: 5x5, two-channel bench with a direct 2-D convolution reference model.
module tb_conv3x3_mc_engine;
    localparam int unsigned DW    = 8;
    localparam int unsigned IMG_W = 5;
    localparam int unsigned IMG_H = 5;
    localparam int unsigned N_OC  = 2;
    localparam int unsigned OW    = 2*DW + 4;
    localparam int unsigned NW    = 9*N_OC;
    localparam int unsigned NPIX  = IMG_W*IMG_H;
    localparam int unsigned AW    = $clog2(NW);

    logic                 clk = 1'b0;
    logic                 Rst_n = 1'b1;
    logic                 start = 1'b0;
    logic                 din_valid = 1'b0;
    logic                 w_we = 1'b0;
    logic [DW-1:0]        din = '0;
    logic [DW-1:0]        w_data = '0;
    logic [AW-1:0]        w_addr = '0;
    logic                 din_ready;
    logic                 dout_valid;
    logic                 busy;
    logic                 frame_done;
    logic [N_OC*OW-1:0]   dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int img [NPIX];
    int wts [NW];
    logic [N_OC*OW-1:0] exp_q[$];
    int                 exp_pix[$];
    logic [N_OC*OW-1:0] obs_val[$];
    int                 obs_cyc[$];

    conv3x3_mc_engine #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .N_OC(N_OC)) dut (
        .clk(clk), .Rst_n(Rst_n), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            obs_val.push_back(dout);
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: plain valid 3x3 convolution over the stored image, raster order.
    function automatic void build_expected();
        logic [N_OC*OW-1:0] v;
        int s;
        exp_q.delete();
        exp_pix.delete();
        for (int r = 2; r < int'(IMG_H); r++) begin
            for (int c = 2; c < int'(IMG_W); c++) begin
                v = '0;
                for (int oc = 0; oc < int'(N_OC); oc++) begin
                    s = 0;
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            s += wts[oc*9 + ky*3 + kx] * img[(r-2+ky)*IMG_W + (c-2+kx)];
`ifdef CONV_RELU_EN
                    if (s < 0) s = 0;
`endif
                    v[oc*OW +: OW] = OW'(s);
                end
                exp_q.push_back(v);
                exp_pix.push_back(r*IMG_W + c);
            end
        end
    endfunction

    function automatic void set_basic();
        for (int i = 0; i < int'(NPIX); i++) img[i] = i;
        for (int i = 0; i < int'(NW); i++) wts[i] = (i < 9) ? 1 : ((i == 13) ? 1 : 0);
    endfunction

    task automatic load_weights();
        for (int i = 0; i < int'(NW); i++) begin
            w_we   = 1'b1;
            w_addr = AW'(i);
            w_data = DW'(wts[i]);
            @(negedge clk);
        end
        w_we = 1'b0;
    endtask

    // Runs one frame from a negedge in IDLE; mode 0 continuous, 1 toggling, 2 random valid.
    task automatic run_frame(input string name, input int mode, input bit hazard);
        int acc[$];
        int p;
        int k;
        int n;
        int last;
        int ai;
        obs_val.delete();
        obs_cyc.delete();
        build_expected();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (din_ready !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s start: din_ready=%b busy=%b frame_done=%b required 1 1 0", name, din_ready, busy, frame_done);
        end
        p = 0;
        k = 0;
        while (p < int'(NPIX) && k < 400) begin
            case (mode)
                0:       din_valid = 1'b1;
                1:       din_valid = (k % 2 == 0);
                default: din_valid = 1'($urandom_range(0, 1));
            endcase
            din = DW'(img[p]);
            if (hazard) begin
                w_we   = 1'b1;
                w_addr = AW'($urandom_range(0, NW-1));
                w_data = DW'($urandom);
                start  = 1'($urandom_range(0, 1));
            end
            if (din_valid && din_ready) begin
                acc.push_back(cyc);
                p++;
            end
            @(negedge clk);
            k++;
        end
        din_valid = 1'b0;
        w_we      = 1'b0;
        start     = 1'b0;
        checks++;
        if (p != int'(NPIX)) begin
            errors++;
            $display("FAIL %s accepts: got %0d required %0d", name, p, NPIX);
        end
        last = (acc.size() > 0) ? acc[acc.size()-1] : 0;
        n = 0;
        while (frame_done !== 1'b1 && n < 20) begin
            if (cyc == last + 3) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_t3: busy=%b required 1", name, busy);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_done !== 1'b1 || cyc != last + 4) begin
            errors++;
            $display("FAIL %s frame_done: at cycle %0d (value %b) required cycle %0d", name, cyc, frame_done, last + 4);
        end
        checks++;
        if (busy !== 1'b0 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s end_idle: busy=%b din_ready=%b required 0 0", name, busy, din_ready);
        end
        checks++;
        if (obs_val.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s result_count: got %0d required %0d", name, obs_val.size(), exp_q.size());
        end
        for (int i = 0; i < obs_val.size() && i < exp_q.size(); i++) begin
            ai = (exp_pix[i] < acc.size()) ? acc[exp_pix[i]] + 3 : -1;
            checks++;
            if (obs_val[i] !== exp_q[i] || obs_cyc[i] != ai) begin
                errors++;
                $display("FAIL %s result[%0d]: dout=%h at cycle %0d required %h at cycle %0d", name, i, obs_val[i], obs_cyc[i], exp_q[i], ai);
            end
        end
        checks++;
        if (dout !== exp_q[exp_q.size()-1]) begin
            errors++;
            $display("FAIL %s dout_hold: dout=%h required %h", name, dout, exp_q[exp_q.size()-1]);
        end
    endtask

    task automatic test_reset();
        #1 Rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dout !== '0 || dout_valid !== 1'b0 || din_ready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: dout=%h dv=%b rdy=%b busy=%b fd=%b required all 0", dout, dout_valid, din_ready, busy, frame_done);
        end
        Rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rdy=%b busy=%b dv=%b required 0 0 0", din_ready, busy, dout_valid);
        end
    endtask

    task automatic test_basic();
        logic [N_OC*OW-1:0] f;
        logic [N_OC*OW-1:0] l;
        set_basic();
        load_weights();
        run_frame("basic", 0, 1'b0);
        f = (obs_val.size() > 0) ? obs_val[0] : 'x;
        l = (obs_val.size() > 0) ? obs_val[obs_val.size()-1] : 'x;
        checks++;
        if (f[0 +: OW] !== OW'(54) || f[OW +: OW] !== OW'(6)) begin
            errors++;
            $display("FAIL basic_first: oc0=%0d oc1=%0d required 54 6", $signed(f[0 +: OW]), $signed(f[OW +: OW]));
        end
        checks++;
        if (l[0 +: OW] !== OW'(162) || l[OW +: OW] !== OW'(18)) begin
            errors++;
            $display("FAIL basic_last: oc0=%0d oc1=%0d required 162 18", $signed(l[0 +: OW]), $signed(l[OW +: OW]));
        end
    endtask

    task automatic test_bubbles();
        set_basic();
        load_weights();
        run_frame("bubbles", 1, 1'b0);
    endtask

    task automatic test_signed();
        logic [OW-1:0] req;
        for (int i = 0; i < int'(NW); i++) wts[i] = -128;
        for (int i = 0; i < int'(NPIX); i++) img[i] = 127;
        load_weights();
        run_frame("signed_neg", 0, 1'b0);
`ifdef CONV_RELU_EN
        req = '0;
`else
        req = OW'(-146304);
`endif
        checks++;
        if (obs_val.size() == 0 || obs_val[0][0 +: OW] !== req || obs_val[0][OW +: OW] !== req) begin
            errors++;
            $display("FAIL signed_neg_value: dout=%h required both channels %h", (obs_val.size() > 0) ? obs_val[0] : 'x, req);
        end
        for (int i = 0; i < int'(NPIX); i++) img[i] = -128;
        run_frame("signed_pos", 0, 1'b0);
        checks++;
        if (obs_val.size() == 0 || obs_val[0][0 +: OW] !== OW'(147456) || obs_val[0][OW +: OW] !== OW'(147456)) begin
            errors++;
            $display("FAIL signed_pos_value: dout=%h required both channels 147456", (obs_val.size() > 0) ? obs_val[0] : 'x);
        end
    endtask

    task automatic test_back_to_back();
        set_basic();
        load_weights();
        run_frame("b2b_first", 0, 1'b0);
        run_frame("b2b_second", 0, 1'b0);
    endtask

    task automatic test_hazards();
        set_basic();
        load_weights();
        w_we   = 1'b1;
        w_addr = AW'(18);
        w_data = 8'h55;
        @(negedge clk);
        w_we   = 1'b0;
        run_frame("hazards", 2, 1'b1);
    endtask

    task automatic test_random();
        logic signed [DW-1:0] t;
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < int'(NW); i++) begin
                t = DW'($urandom);
                wts[i] = int'(t);
            end
            for (int i = 0; i < int'(NPIX); i++) begin
                t = DW'($urandom);
                img[i] = int'(t);
            end
            load_weights();
            run_frame("random", 2, 1'b0);
        end
    endtask

    task automatic test_reset_midframe();
        int p;
        int k;
        set_basic();
        load_weights();
        run_frame("pre_reset", 0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        p = 0;
        k = 0;
        while (p < 10 && k < 50) begin
            din_valid = 1'b1;
            din = DW'(img[p]);
            if (din_ready) p++;
            @(negedge clk);
            k++;
        end
        din_valid = 1'b0;
        #2 Rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== '0 || dout_valid !== 1'b0 || din_ready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: dout=%h dv=%b rdy=%b busy=%b fd=%b required all 0", dout, dout_valid, din_ready, busy, frame_done);
        end
        @(negedge clk);
        Rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < int'(NW); i++) wts[i] = 0;
        run_frame("zero_weights", 0, 1'b0);
        set_basic();
        load_weights();
        run_frame("reload", 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_signed();
        test_back_to_back();
        test_hazards();
        test_random();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
